// File: rtl/glitcbus_space_arbiter_v3.sv
// -----------------------------------------------------------------------------
// glitcbus_space_arbiter_v3
//
// Decodes a GLITCBUS strobe into one of NUM_SPACES 16-register address spaces.
// It forwards a single-cycle read/write strobe to the selected space and waits
// for that space's acknowledge. It then completes the bus transaction with a
// single-cycle gb_ack_o. A transaction is abandoned with ERR_PATTERN read data
// if the space does not answer within TIMEOUT wait cycles, or if the space
// index is not mapped. Abandoned transactions bump a saturating error counter.
//
// Ports
//   clk_i          : bus clock, the only clock
//   rst_i          : synchronous, active-high reset
//   gb_adr_i       : bus address; space index is gb_adr_i[SPACE_LSB+3:SPACE_LSB]
//   gb_wr_i/gb_rd_i: single-cycle bus strobes (both high counts as a write)
//   gb_dat_o       : registered read data to the bus
//   gb_ack_o       : single-cycle transaction completion
//   slv_sel_o      : registered one-hot space select, held for the whole wait
//   slv_wr_o/rd_o  : single-cycle strobes to the selected space
//   slv_dat_i      : space k read data at [k*DATA_WIDTH +: DATA_WIDTH]
//   slv_ack_i      : per-space completion; only the selected bit is honoured
//   busy_o         : high while a transaction is outstanding
//   timeout_cnt_o  : saturating count of abandoned transactions
// -----------------------------------------------------------------------------
module glitcbus_space_arbiter_v3 #(
  parameter int                    NUM_SPACES  = 8,
  parameter int                    SPACE_LSB   = 4,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    TIMEOUT     = 15,
  parameter logic [DATA_WIDTH-1:0] ERR_PATTERN = 32'hBADADD00
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [15:0]                      gb_adr_i,
  input  logic                             gb_wr_i,
  input  logic                             gb_rd_i,
  output logic [DATA_WIDTH-1:0]            gb_dat_o,
  output logic                             gb_ack_o,
  output logic [NUM_SPACES-1:0]            slv_sel_o,
  output logic                             slv_wr_o,
  output logic                             slv_rd_o,
  input  logic [NUM_SPACES*DATA_WIDTH-1:0] slv_dat_i,
  input  logic [NUM_SPACES-1:0]            slv_ack_i,
  output logic                             busy_o,
  output logic [7:0]                       timeout_cnt_o
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   dat_reg, dat_next;
  logic                    ack_reg, ack_next;
  logic [NUM_SPACES-1:0]   sel_reg, sel_next;
  logic                    wr_reg, wr_next;
  logic                    rd_reg, rd_next;
  logic [7:0]              timer_reg, timer_next;
  logic [7:0]              tcnt_reg, tcnt_next;
  logic                    is_wr_reg, is_wr_next;
  logic                    unmapped_reg, unmapped_next;

  logic                    strobe;
  logic [3:0]              space_idx;
  logic                    mapped;
  logic [NUM_SPACES-1:0]   sel_onehot;
  logic                    slave_ack;
  logic                    timed_out;
  logic                    done;
  logic                    err_done;
  logic [DATA_WIDTH-1:0]   dat_masked [NUM_SPACES];
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    unused_adr_bits;

  assign strobe    = gb_wr_i | gb_rd_i;
  assign space_idx = gb_adr_i[SPACE_LSB +: 4];
  assign mapped    = ({1'b0, space_idx} < 5'(NUM_SPACES));
  // Only the space index field matters; the remaining address bits belong to
  // the register offset inside the space and are decoded by the slave.
  assign unused_adr_bits = ^gb_adr_i;

  // The select register is one-hot during a mapped wait and all-zero
  // otherwise, so masking with it both picks the right ack/data and
  // ignores every unselected space.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPACES; gi++) begin : g_space
      assign sel_onehot[gi] = (space_idx == 4'(gi));
      assign dat_masked[gi] = slv_dat_i[gi*DATA_WIDTH +: DATA_WIDTH]
                              & {DATA_WIDTH{sel_reg[gi]}};
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_SPACES; k++) begin
      rd_mux = rd_mux | dat_masked[k];
    end
  end

  assign slave_ack = |(slv_ack_i & sel_reg);
  // Timer counts completed wait cycles; the last allowed wait cycle is the
  // one where it would step up to TIMEOUT. An ack in that cycle still wins.
  assign timed_out = (timer_reg == 8'(TIMEOUT - 1));
  // Unmapped spaces spend exactly one cycle in WAIT and then error out.
  assign done      = unmapped_reg | slave_ack | timed_out;
  assign err_done  = unmapped_reg | (~slave_ack & timed_out);

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      dat_reg      <= '0;
      ack_reg      <= 1'b0;
      sel_reg      <= '0;
      wr_reg       <= 1'b0;
      rd_reg       <= 1'b0;
      timer_reg    <= 8'd0;
      tcnt_reg     <= 8'd0;
      is_wr_reg    <= 1'b0;
      unmapped_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dat_reg      <= dat_next;
      ack_reg      <= ack_next;
      sel_reg      <= sel_next;
      wr_reg       <= wr_next;
      rd_reg       <= rd_next;
      timer_reg    <= timer_next;
      tcnt_reg     <= tcnt_next;
      is_wr_reg    <= is_wr_next;
      unmapped_reg <= unmapped_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (strobe) state_next = ST_WAIT;
      ST_WAIT: if (done)   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    dat_next      = dat_reg;
    ack_next      = 1'b0;
    sel_next      = sel_reg;
    wr_next       = 1'b0;
    rd_next       = 1'b0;
    timer_next    = timer_reg;
    tcnt_next     = tcnt_reg;
    is_wr_next    = is_wr_reg;
    unmapped_next = unmapped_reg;
    case (state_reg)
      ST_IDLE: begin
        if (strobe) begin
          is_wr_next    = gb_wr_i;
          unmapped_next = ~mapped;
          timer_next    = 8'd0;
          if (mapped) begin
            sel_next = sel_onehot;
            wr_next  = gb_wr_i;
            rd_next  = ~gb_wr_i;
          end
        end
      end
      ST_WAIT: begin
        if (done) begin
          ack_next = 1'b1;
          sel_next = '0;
          if (!is_wr_reg) begin
            dat_next = err_done ? ERR_PATTERN : rd_mux;
          end
          if (err_done && (tcnt_reg != 8'hFF)) begin
            tcnt_next = tcnt_reg + 8'd1;
          end
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign gb_dat_o      = dat_reg;
  assign gb_ack_o      = ack_reg;
  assign slv_sel_o     = sel_reg;
  assign slv_wr_o      = wr_reg;
  assign slv_rd_o      = rd_reg;
  assign busy_o        = (state_reg == ST_WAIT);
  assign timeout_cnt_o = tcnt_reg;

endmodule
